// File: rtl/magnetron_pkg.sv
// Shared definitions for the magnetron power controller: state codes and default sizing.
package magnetron_pkg;

    localparam int DEF_PWR_W  = 4;
    localparam int DEF_PERIOD = 10;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COOK  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/button_edge.sv
// Falling-edge detector for an active-low, already-synchronised button.
// A held button yields exactly one press cycle.
module button_edge (
    input  logic clk,
    input  logic resetn,
    input  logic btn_n,
    output logic press
);

    logic prev_n;

    always_ff @(posedge clk) begin
        if (!resetn) prev_n <= 1'b1;
        else         prev_n <= btn_n;
    end

    assign press = prev_n & ~btn_n;

endmodule

// File: rtl/magnetron_ctrl_pwm.sv
// Magnetron cook/pause/done sequencer with slot-based power duty cycling
// and a combinational door interlock on mag_on.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; level_q held at 0
// ST_COOK  | cooking; slot counter runs, magnetron duty-cycled
// ST_PAUSE | stopped or door opened; slot frozen, level_q kept
// ST_DONE  | timer expired; waits for clear or door open
module magnetron_ctrl_pwm
    import magnetron_pkg::*;
#(
    parameter int PWR_W  = DEF_PWR_W,
    parameter int PERIOD = DEF_PERIOD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [PWR_W-1:0] power_level,
    output logic             mag_on,
    output logic [1:0]       state,
    output logic [PWR_W-1:0] level_q
);

    state_t             state_r;
    logic [CNT_W-1:0]   slot;
    logic               mag_q;
    logic               start_press;
    logic               stop_press;
    logic [PWR_W-1:0]   level_clamp;
    logic               slot_lt_level;
    logic [CNT_W-1:0]   slot_next;

    button_edge u_start_edge (
        .clk    (clk),
        .resetn (resetn),
        .btn_n  (startn),
        .press  (start_press)
    );

    button_edge u_stop_edge (
        .clk    (clk),
        .resetn (resetn),
        .btn_n  (stopn),
        .press  (stop_press)
    );

    assign level_clamp = ({1'b0, power_level} > (PWR_W+1)'(PERIOD)) ? PWR_W'(PERIOD) : power_level;
    assign slot_lt_level = {{PWR_W{1'b0}}, slot} < {{CNT_W{1'b0}}, level_q};
    assign slot_next = (slot == CNT_W'(PERIOD - 1)) ? '0 : slot + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            slot    <= '0;
            level_q <= '0;
            mag_q   <= 1'b0;
        end else begin
            mag_q <= (state_r == ST_COOK) && slot_lt_level;
            case (state_r)
                ST_IDLE: begin
                    // stop, timer_done, clear or open door all veto a start
                    if (clearn && door_closed && !stop_press && !timer_done && start_press) begin
                        state_r <= ST_COOK;
                        level_q <= level_clamp;
                        slot    <= '0;
                    end
                end
                ST_COOK: begin
                    if (!clearn) begin
                        state_r <= ST_IDLE;
                        level_q <= '0;
                    end else if (!door_closed || stop_press) begin
                        state_r <= ST_PAUSE;
                    end else if (timer_done) begin
                        state_r <= ST_DONE;
                    end else begin
                        slot <= slot_next;
                    end
                end
                ST_PAUSE: begin
                    if (!clearn) begin
                        state_r <= ST_IDLE;
                        level_q <= '0;
                    end else if (door_closed) begin
                        if (stop_press) begin
                            state_r <= ST_IDLE;
                            level_q <= '0;
                        end else if (timer_done) begin
                            state_r <= ST_DONE;
                        end else if (start_press) begin
                            state_r <= ST_COOK;
                            slot    <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (!clearn || !door_closed) begin
                        state_r <= ST_IDLE;
                        level_q <= '0;
                    end
                end
            endcase
        end
    end

    assign mag_on = mag_q & door_closed;
    assign state  = state_r;

endmodule

// File: tb/tb_magnetron_ctrl_pwm.sv
// Bench for magnetron_ctrl_pwm: directed vector table, corner-case sequences,
// and randomized traffic checked every cycle against a behavioural model.
module tb_magnetron_ctrl_pwm;

    localparam int PERIOD = 10;
    localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0, startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic       door_closed = 1'b1, timer_done = 1'b0;
    logic [3:0] power_level = 4'd10;
    logic       mag_on;
    logic [1:0] state;
    logic [3:0] level_q;

    int n_pass = 0, n_total = 0;

    // model: cook progress kept as an unbounded cycle count; slot is count mod PERIOD
    int m_state = M_IDLE, m_cnt = 0, m_level = 0;
    bit m_mag = 0, m_pstart = 1, m_pstop = 1;

    magnetron_ctrl_pwm #(.PWR_W(4), .PERIOD(PERIOD), .CNT_W(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .power_level (power_level),
        .mag_on      (mag_on),
        .state       (state),
        .level_q     (level_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit sp, pp, mag_n;
        int nxt;
        if (!resetn) begin
            m_state = M_IDLE; m_cnt = 0; m_level = 0; m_mag = 0;
            m_pstart = 1; m_pstop = 1;
            return;
        end
        sp = m_pstart && !startn;
        pp = m_pstop && !stopn;
        mag_n = (m_state == M_COOK) && ((m_cnt % PERIOD) < m_level);
        nxt = m_state;
        case (m_state)
            M_IDLE:  if (clearn && door_closed && !pp && !timer_done && sp) nxt = M_COOK;
            M_COOK:  if (!clearn) nxt = M_IDLE;
                     else if (!door_closed || pp) nxt = M_PAUSE;
                     else if (timer_done) nxt = M_DONE;
            M_PAUSE: if (!clearn) nxt = M_IDLE;
                     else if (door_closed) begin
                         if (pp) nxt = M_IDLE;
                         else if (timer_done) nxt = M_DONE;
                         else if (sp) nxt = M_COOK;
                     end
            default: if (!clearn || !door_closed) nxt = M_IDLE;
        endcase
        if (nxt == M_COOK && m_state != M_COOK) begin
            m_cnt = 0;
            if (m_state == M_IDLE) m_level = (power_level > PERIOD) ? PERIOD : int'(power_level);
        end else if (nxt == M_COOK) begin
            m_cnt++;
        end
        if (nxt == M_IDLE) m_level = 0;
        m_state = nxt; m_mag = mag_n; m_pstart = startn; m_pstop = stopn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_state", int'(state), m_state);
        check("model_level", int'(level_q), m_level);
        check("model_mag", int'(mag_on), int'(m_mag & door_closed));
    endtask

    typedef struct {
        bit         rst, sn, pn, cn, dc, td;
        logic [3:0] pl;
        int         reps;
        logic [1:0] e_state;
        bit         e_mag;
        logic [3:0] e_level;
    } vec_t;

    vec_t tbl[10];

    initial begin
        //          rst sn pn cn dc td  pl  reps st   mag lvl
        tbl[0] = '{0, 1, 1, 1, 1, 0, 4'd10, 2, 2'd0, 0, 4'd0};
        tbl[1] = '{1, 1, 1, 1, 1, 0, 4'd10, 1, 2'd0, 0, 4'd0};
        tbl[2] = '{1, 0, 1, 1, 1, 0, 4'd10, 1, 2'd1, 0, 4'd10};
        tbl[3] = '{1, 1, 1, 1, 1, 0, 4'd10, 30, 2'd1, 1, 4'd10};
        tbl[4] = '{1, 1, 1, 1, 1, 1, 4'd10, 1, 2'd3, 1, 4'd10};
        tbl[5] = '{1, 1, 1, 1, 1, 1, 4'd10, 1, 2'd3, 0, 4'd10};
        tbl[6] = '{1, 1, 1, 0, 1, 0, 4'd10, 1, 2'd0, 0, 4'd0};
        tbl[7] = '{1, 1, 1, 1, 1, 0, 4'd10, 1, 2'd0, 0, 4'd0};
        tbl[8] = '{1, 0, 0, 1, 1, 0, 4'd10, 1, 2'd0, 0, 4'd0};
        tbl[9] = '{1, 1, 1, 1, 1, 0, 4'd10, 1, 2'd0, 0, 4'd0};

        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                resetn = tbl[i].rst; startn = tbl[i].sn; stopn = tbl[i].pn;
                clearn = tbl[i].cn; door_closed = tbl[i].dc; timer_done = tbl[i].td;
                power_level = tbl[i].pl;
                tick();
                check($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].e_state));
                check($sformatf("vec%0d_mag", i), int'(mag_on), int'(tbl[i].e_mag));
                check($sformatf("vec%0d_level", i), int'(level_q), int'(tbl[i].e_level));
            end
        end

        // level 3: 3 high / 7 low, unaffected by power_level changes mid-cook
        power_level = 4'd3; startn = 1'b0; tick();
        check("duty3_enter", int'(state), 1);
        startn = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k == 25) power_level = 4'd8;
            tick();
            check("duty3_pattern", int'(mag_on), int'(((k - 1) % PERIOD) < 3));
        end
        check("duty3_level_kept", int'(level_q), 3);
        stopn = 1'b0; tick(); check("stop1_pause", int'(state), 2);
        stopn = 1'b1; tick();
        stopn = 1'b0; tick(); check("stop2_idle", int'(state), 0);
        check("stop2_level", int'(level_q), 0);
        stopn = 1'b1; tick();

        // door interlock, pause, resume
        power_level = 4'd10; startn = 1'b0; tick();
        startn = 1'b1; repeat (5) tick();
        check("pre_cut_mag", int'(mag_on), 1);
        door_closed = 1'b0; #1;
        check("door_cut_comb", int'(mag_on), 0);
        tick(); check("door_pause", int'(state), 2);
        tick();
        door_closed = 1'b1;
        repeat (3) begin
            tick();
            check("closed_still_pause", int'(state), 2);
            check("closed_mag_off", int'(mag_on), 0);
        end
        startn = 1'b0; tick(); check("resume_cook", int'(state), 1);
        startn = 1'b1; tick(); check("resume_mag", int'(mag_on), 1);
        clearn = 1'b0; tick(); check("clear_cook", int'(state), 0);
        check("clear_level", int'(level_q), 0);
        clearn = 1'b1; tick();

        // held start with door open never becomes a press later
        door_closed = 1'b0; startn = 1'b0;
        repeat (20) begin tick(); check("held_open_idle", int'(state), 0); end
        door_closed = 1'b1;
        repeat (3) begin tick(); check("held_closed_idle", int'(state), 0); end
        startn = 1'b1; tick();
        startn = 1'b0; tick(); check("repress_cook", int'(state), 1);
        startn = 1'b1; tick();
        clearn = 1'b0; tick(); clearn = 1'b1; tick();

        // level 0 never fires
        power_level = 4'd0; startn = 1'b0; tick();
        check("lvl0_cook", int'(state), 1);
        startn = 1'b1;
        repeat (20) begin tick(); check("lvl0_mag", int'(mag_on), 0); end
        clearn = 1'b0; tick(); clearn = 1'b1; tick();

        // level 15 clamps to PERIOD: always on
        power_level = 4'd15; startn = 1'b0; tick();
        check("clamp_level", int'(level_q), PERIOD);
        startn = 1'b1;
        repeat (21) begin tick(); check("clamp_mag", int'(mag_on), 1); end
        resetn = 1'b0; tick();
        check("rst_state", int'(state), 0);
        check("rst_mag", int'(mag_on), 0);
        resetn = 1'b1; tick();

        // randomized traffic against the model, including the door path between edges
        for (int n = 0; n < 3000; n++) begin
            resetn      = ($urandom_range(63) != 0);
            startn      = ($urandom_range(3) != 0);
            stopn       = ($urandom_range(7) != 0);
            clearn      = ($urandom_range(31) != 0);
            door_closed = ($urandom_range(9) != 0);
            timer_done  = ($urandom_range(19) == 0);
            power_level = 4'($urandom_range(15));
            #1;
            check("rand_mag_comb", int'(mag_on), int'(m_mag & door_closed));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
